img_mem_arbiter: RTL and testbench

//   Shares the single-port image SRAM between the pixel-fetch path (read requester)
//   and the result write-back path (write requester) of the image processor.

---
 rtl/img_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_img_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_mem_arbiter.sv
// Shares one single-port image SRAM between a pixel read requester and a write-back requester,
// with bounded back-to-back grants per side and PAD_VALUE returned for out-of-image reads.
module img_mem_arbiter #(
  parameter int                  ADDR_W    = 32,
  parameter int                  DATA_W    = 24,
  parameter int                  SIZE      = 16384,
  parameter logic [DATA_W-1:0]   PAD_VALUE = '0,
  parameter int                  MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_oob
);

  localparam int                CNT_W  = $clog2(MAX_BURST + 1);
  localparam logic [ADDR_W-1:0] SIZE_A = ADDR_W'(SIZE);
  localparam logic [CNT_W-1:0]  MAX_C  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]  ONE_C  = CNT_W'(1);

  typedef enum logic {OWN_RD = 1'b0, OWN_WR = 1'b1} owner_e;

  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_pad_q, rd_pad_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              rd_oob, wr_oob, burst_ok;
  logic              gnt_rd, gnt_wr;
  owner_e            gnt_side;
  logic [DATA_W-1:0] rdata_sel;

  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    rd_pend_d = 1'b0;
    rd_pad_d  = 1'b0;
    err_d     = err_q;
    gnt_rd    = 1'b0;
    gnt_wr    = 1'b0;
    gnt_side  = OWN_RD;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    rd_oob   = (rd_addr >= SIZE_A);
    wr_oob   = (wr_addr >= SIZE_A);
    burst_ok = (cnt_q < MAX_C);

    // Under contention the current owner keeps the port until its burst budget runs out.
    if (!rst) begin
      if (rd_req && wr_req) begin
        gnt_rd = (owner_q == OWN_RD) ? burst_ok : !burst_ok;
        gnt_wr = !gnt_rd;
      end else begin
        gnt_rd = rd_req;
        gnt_wr = wr_req;
      end
    end

    if (gnt_rd || gnt_wr) begin
      gnt_side = gnt_wr ? OWN_WR : OWN_RD;
      if (gnt_side == owner_q) begin
        cnt_d = burst_ok ? cnt_q + ONE_C : cnt_q;
      end else begin
        owner_d = gnt_side;
        cnt_d   = ONE_C;
      end
    end else begin
      cnt_d = '0;
    end

    if (gnt_rd) begin
      rd_pend_d = 1'b1;
      rd_pad_d  = rd_oob;
      if (!rd_oob) begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
    end

    if (gnt_wr) begin
      if (wr_oob) begin
        err_d = 1'b1;
      end else begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end

    // SRAM data arrives in the cycle after the access, so it is forwarded straight through
    // and captured for the hold value.
    rdata_sel = rd_pend_q ? (rd_pad_q ? PAD_VALUE : mem_rdata) : rdata_q;
    rdata_d   = rdata_sel;
  end

  assign rd_gnt    = gnt_rd;
  assign wr_gnt    = gnt_wr;
  assign rd_rvalid = rd_pend_q & ~rst;
  assign rd_rdata  = rst ? '0 : rdata_sel;
  assign err_oob   = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_RD;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_pad_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_pad_q  <= rd_pad_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Bench for img_mem_arbiter: vector table, directed corner sequences, and a random run
// checked every cycle against a grant-history reference model.
module tb_img_mem_arbiter;

  localparam int SIZE = 16384;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        wr_req = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic [23:0] mem_rdata = '0;
  logic        rd_gnt, rd_rvalid, wr_gnt, mem_en, mem_we, err_oob;
  logic [23:0] rd_rdata, mem_wdata;
  logic [31:0] mem_addr;

  int total = 0;
  int bad   = 0;

  img_mem_arbiter #(.ADDR_W(32), .DATA_W(24), .SIZE(SIZE), .PAD_VALUE(24'h0), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] init_f(input logic [13:0] a);
    return 24'(32'(a) * 32'd2654435 + 32'd12345);
  endfunction

  // SRAM macro: one access per cycle, read data one cycle after the enable.
  logic [23:0] sram [SIZE];
  bit          sram_wr [SIZE];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        sram[mem_addr[13:0]]    <= mem_wdata;
        sram_wr[mem_addr[13:0]] <= 1'b1;
      end else begin
        mem_rdata <= sram_wr[mem_addr[13:0]] ? sram[mem_addr[13:0]] : init_f(mem_addr[13:0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: image contents as an array, arbitration derived from the recent grant history.
  logic [23:0] gold [SIZE];
  bit          gold_wr [SIZE];
  int          hist[$];
  logic        m_pend = 1'b0;
  logic        m_err  = 1'b0;
  logic [23:0] m_pdata = '0;
  logic [23:0] m_hold  = '0;

  always @(negedge clk) begin : mon
    int   own, run;
    logic grd, gwr, ro, wo, e_en, e_we;
    if (rst) begin
      chk("rst_ctl", {rd_gnt, wr_gnt, mem_en, mem_we, rd_rvalid, err_oob}, 64'd0);
      chk("rst_bus", {mem_addr, mem_wdata}, 64'd0);
      chk("rst_rdata", rd_rdata, 64'd0);
      hist.delete();
      m_pend = 1'b0;
      m_hold = '0;
      m_err  = 1'b0;
    end else begin
      chk("rvalid", rd_rvalid, m_pend);
      chk("rdata", rd_rdata, m_pend ? m_pdata : m_hold);
      if (m_pend) m_hold = m_pdata;
      chk("err_oob", err_oob, m_err);
      own = 0;
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] >= 0) begin
          own = hist[i];
          break;
        end
      end
      for (int i = hist.size() - 1; i >= 0 && hist[i] == own; i--) run++;
      grd  = rd_req && (!wr_req || ((own == 0) == (run < MAXB)));
      gwr  = wr_req && !grd;
      ro   = (rd_addr >= 32'(SIZE));
      wo   = (wr_addr >= 32'(SIZE));
      e_en = (grd && !ro) || (gwr && !wo);
      e_we = gwr && !wo;
      chk("gnt", {rd_gnt, wr_gnt}, {grd, gwr});
      chk("mem_ctl", {mem_en, mem_we}, {e_en, e_we});
      if (e_en) chk("mem_addr", mem_addr, grd ? rd_addr : wr_addr);
      if (e_we) chk("mem_wdata", mem_wdata, wr_data);
      m_pend  = grd;
      m_pdata = ro ? 24'h0 : (gold_wr[rd_addr[13:0]] ? gold[rd_addr[13:0]] : init_f(rd_addr[13:0]));
      if (gwr && wo) m_err = 1'b1;
      if (e_we) begin
        gold[wr_addr[13:0]]    = wr_data;
        gold_wr[wr_addr[13:0]] = 1'b1;
      end
      hist.push_back(grd ? 0 : (gwr ? 1 : -1));
      if (hist.size() > 16) void'(hist.pop_front());
    end
  end

  typedef struct {
    logic        r, rq;
    logic [31:0] ra;
    logic        wq;
    logic [31:0] wa;
    logic [23:0] wd;
    logic        e_rg, e_wg, e_en, e_we;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic r, rq, input logic [31:0] ra, input logic wq,
                              input logic [31:0] wa, input logic [23:0] wd,
                              input logic e_rg, e_wg, e_en, e_we, input logic [31:0] e_addr);
    vec_t v;
    v.r = r; v.rq = rq; v.ra = ra; v.wq = wq; v.wa = wa; v.wd = wd;
    v.e_rg = e_rg; v.e_wg = e_wg; v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic drive(input logic r, rq, input logic [31:0] ra, input logic wq,
                       input logic [31:0] wa, input logic [23:0] wd);
    @(posedge clk);
    #1;
    rst = r; rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 24'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom % 8;
    case (k)
      0:       return 32'(SIZE) + ($urandom % 100);
      1:       return $urandom;
      2:       return 32'(SIZE - 1);
      default: return $urandom % 16;
    endcase
  endfunction

  vec_t tbl [10];

  initial begin
    tbl[0] = mk(1, 1, 32'd3,     1, 32'd4,        24'h111111, 0, 0, 0, 0, 32'd0);
    tbl[1] = mk(0, 1, 32'd3,     0, 32'd0,        24'h0,      1, 0, 1, 0, 32'd3);
    tbl[2] = mk(0, 0, 32'd0,     1, 32'd4,        24'h111111, 0, 1, 1, 1, 32'd4);
    tbl[3] = mk(0, 1, 32'd8,     1, 32'd9,        24'h222222, 0, 1, 1, 1, 32'd9);
    tbl[4] = mk(0, 1, 32'd8,     0, 32'd0,        24'h0,      1, 0, 1, 0, 32'd8);
    tbl[5] = mk(0, 0, 32'd0,     0, 32'd0,        24'h0,      0, 0, 0, 0, 32'd0);
    tbl[6] = mk(0, 1, 32'd16384, 0, 32'd0,        24'h0,      1, 0, 0, 0, 32'd0);
    tbl[7] = mk(0, 0, 32'd0,     1, 32'd20000,    24'h333333, 0, 1, 0, 0, 32'd0);
    tbl[8] = mk(0, 0, 32'd0,     1, 32'hFFFFFFFF, 24'h444444, 0, 1, 0, 0, 32'd0);
    tbl[9] = mk(0, 1, 32'd16383, 0, 32'd0,        24'h0,      1, 0, 1, 0, 32'd16383);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].r, tbl[i].rq, tbl[i].ra, tbl[i].wq, tbl[i].wa, tbl[i].wd);
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", i), {rd_gnt, wr_gnt, mem_en, mem_we},
          {tbl[i].e_rg, tbl[i].e_wg, tbl[i].e_en, tbl[i].e_we});
      if (tbl[i].e_en) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].e_we) chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].wd);
    end

    // Read of a known pixel, then the data hold on an idle cycle.
    drive(1, 0, 32'd0, 0, 32'd0, 24'd0);
    drive(0, 0, 32'd0, 1, 32'd5, 24'hABCDEF);
    @(negedge clk); chk("A_wgnt", wr_gnt, 1);
    drive(0, 1, 32'd5, 0, 32'd0, 24'd0);
    @(negedge clk); chk("A_rgnt", rd_gnt, 1);
    idle();
    @(negedge clk); chk("A_rvalid", rd_rvalid, 1); chk("A_rdata", rd_rdata, 24'hABCDEF);
    idle();
    @(negedge clk); chk("A_hold", {rd_rvalid, rd_rdata}, {1'b0, 24'hABCDEF});

    // Padding read at exactly SIZE.
    drive(0, 1, 32'd16384, 0, 32'd0, 24'd0);
    @(negedge clk); chk("B_gnt_en", {rd_gnt, mem_en}, 2'b10);
    idle();
    @(negedge clk); chk("B_rvalid", rd_rvalid, 1); chk("B_rdata", rd_rdata, 24'h0);

    // Both sides saturating: bursts of MAX_BURST alternate with no idle cycle.
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 32'd10, 1, 32'd11, 24'h5A5A5A);
      @(negedge clk);
      chk($sformatf("C_burst%0d", i), {rd_gnt, wr_gnt}, ((i / MAXB) % 2 == 0) ? 2'b10 : 2'b01);
    end
    idle();

    // Out-of-image write is dropped and latches the sticky error until reset.
    drive(1, 0, 32'd0, 0, 32'd0, 24'd0);
    drive(0, 0, 32'd0, 1, 32'd20000, 24'hFFFFFF);
    @(negedge clk); chk("D_gnt_en", {wr_gnt, mem_en}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge clk); chk($sformatf("D_err%0d", i), err_oob, 1);
    end
    drive(1, 0, 32'd0, 0, 32'd0, 24'd0);
    idle();
    @(negedge clk); chk("D_err_clr", err_oob, 0);

    // Reset right after a read grant cancels the response.
    drive(0, 1, 32'd5, 0, 32'd0, 24'd0);
    @(negedge clk); chk("E_rgnt", rd_gnt, 1);
    drive(1, 0, 32'd0, 0, 32'd0, 24'd0);
    @(negedge clk);
    chk("E_rst_outs", {rd_gnt, wr_gnt, mem_en, mem_we, rd_rvalid, err_oob, rd_rdata}, 64'd0);
    idle();
    @(negedge clk); chk("E_no_rvalid", {rd_rvalid, rd_rdata}, 64'd0);

    // Write then immediate read of the same pixel.
    drive(0, 0, 32'd0, 1, 32'd7, 24'h123456);
    @(negedge clk); chk("F_wgnt", wr_gnt, 1);
    drive(0, 1, 32'd7, 0, 32'd0, 24'd0);
    @(negedge clk); chk("F_rgnt", rd_gnt, 1);
    idle();
    @(negedge clk); chk("F_rdata", {rd_rvalid, rd_rdata}, {1'b1, 24'h123456});

    // Random traffic honouring hold-until-grant, with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      logic grd, gwr;
      @(negedge clk);
      grd = rd_gnt;
      gwr = wr_gnt;
      @(posedge clk);
      #1;
      rst = ($urandom % 400) == 0;
      if (!rd_req || grd) begin
        rd_req  = ($urandom % 3) != 0;
        rd_addr = rand_addr();
      end
      if (!wr_req || gwr) begin
        wr_req  = ($urandom % 3) != 0;
        wr_addr = rand_addr();
        wr_data = 24'($urandom);
      end
    end
    idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
